// File: rtl/atm_pkg.sv
// Shared opcode, status and FSM encodings for the balance access arbiter.
package atm_pkg;

   typedef enum logic [1:0] {
      OP_WDRAW = 2'b00,
      OP_DEP   = 2'b01,
      OP_INQ   = 2'b10,
      OP_BAD   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      STS_OK    = 3'b000,
      STS_NSF   = 3'b001,
      STS_OVF   = 3'b010,
      STS_LIMIT = 3'b011,
      STS_BADOP = 3'b100
   } sts_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_EXEC,
      S_RESP
   } fsm_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/atm_rr_arbiter.sv
// Round-robin winner select; ptr_q holds the highest-priority terminal,
// moved to just past the winner on every grant.
module atm_rr_arbiter
   import atm_pkg::*;
#(
   parameter int NUM_TERM = 4,
   parameter int IDX_W    = idx_w(NUM_TERM)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_TERM-1:0] req_i,
   input  logic                adv_i,
   output logic                gnt_vld_o,
   output logic [IDX_W-1:0]    gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Scan from farthest to nearest so the nearest requester wins.
   always_comb begin
      logic [IDX_W-1:0] k;
      k         = '0;
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      for (int i = NUM_TERM - 1; i >= 0; i--) begin
         k = IDX_W'((int'(ptr_q) + i) % NUM_TERM);
         if (req_i[k]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = k;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv_i && gnt_vld_o) begin
         if (gnt_idx_o == IDX_W'(NUM_TERM - 1))
            ptr_d = '0;
         else
            ptr_d = gnt_idx_o + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end

endmodule

// File: rtl/balance_access_arbiter.sv
// Shared-balance transaction arbiter: IDLE->GRANT->EXEC->RESP per request.
// Daily withdraw cap is built only with ATM_DAILY_LIMIT_EN defined.
module balance_access_arbiter
   import atm_pkg::*;
#(
   parameter int NUM_TERM    = 4,
   parameter int BAL_W       = 8,
   parameter int AMT_W       = 6,
   parameter int INIT_BAL    = 50,
   parameter int DAILY_LIMIT = 100
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_TERM-1:0]       req,
   input  logic [2*NUM_TERM-1:0]     op,
   input  logic [AMT_W*NUM_TERM-1:0] amt,
   input  logic                      day_clr,
   output logic [NUM_TERM-1:0]       ack,
   output logic [2:0]                status,
   output logic [BAL_W-1:0]          balance,
   output logic                      busy
);

   localparam int IDX_W = idx_w(NUM_TERM);
   localparam int SUM_W = ((BAL_W > AMT_W) ? BAL_W : AMT_W) + 1;
   localparam logic [SUM_W-1:0] BAL_MAX = SUM_W'({BAL_W{1'b1}});

   fsm_e             state_q, state_d;
   logic             gnt_vld;
   logic [IDX_W-1:0] gnt_idx;
   logic             take;
   logic [1:0]       op_sel;
   logic [AMT_W-1:0] amt_sel;
   logic [IDX_W-1:0] idx_q;
   op_e              op_q;
   logic [AMT_W-1:0] amt_q;
   logic [BAL_W-1:0] bal_q, bal_d;
   sts_e             sts_q, sts_d;
   logic             lim_hit;
   logic             wd_ok;
   logic [SUM_W-1:0] bal_x, amt_x, sum_x, dif_x;

   atm_rr_arbiter #(
      .NUM_TERM (NUM_TERM),
      .IDX_W    (IDX_W)
   ) u_rr (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req),
      .adv_i     (state_q == S_IDLE),
      .gnt_vld_o (gnt_vld),
      .gnt_idx_o (gnt_idx)
   );

   assign take = (state_q == S_IDLE) && gnt_vld;

   always_comb begin
      op_sel  = '0;
      amt_sel = '0;
      for (int i = 0; i < NUM_TERM; i++) begin
         if (gnt_idx == IDX_W'(i)) begin
            op_sel  = op[2*i +: 2];
            amt_sel = amt[AMT_W*i +: AMT_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (gnt_vld) state_d = S_GRANT;
         S_GRANT: state_d = S_EXEC;
         S_EXEC:  state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != S_IDLE);
      ack    = '0;
      status = STS_OK;
      if (state_q == S_RESP) begin
         ack[idx_q] = 1'b1;
         status     = sts_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q <= '0;
         op_q  <= OP_WDRAW;
         amt_q <= '0;
      end else if (take) begin
         idx_q <= gnt_idx;
         op_q  <= op_e'(op_sel);
         amt_q <= amt_sel;
      end
   end

   assign bal_x = SUM_W'(bal_q);
   assign amt_x = SUM_W'(amt_q);
   assign sum_x = bal_x + amt_x;
   assign dif_x = bal_x - amt_x;

   // Limit is checked ahead of funds so a capped withdraw reports LIMIT.
   always_comb begin
      bal_d = bal_q;
      sts_d = STS_OK;
      wd_ok = 1'b0;
      unique case (op_q)
         OP_WDRAW: begin
            if (lim_hit) sts_d = STS_LIMIT;
            else if (amt_x > bal_x) sts_d = STS_NSF;
            else begin
               bal_d = BAL_W'(dif_x);
               wd_ok = 1'b1;
            end
         end
         OP_DEP: begin
            if (sum_x > BAL_MAX) sts_d = STS_OVF;
            else bal_d = BAL_W'(sum_x);
         end
         OP_INQ: sts_d = STS_OK;
         OP_BAD: sts_d = STS_BADOP;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bal_q <= BAL_W'(INIT_BAL);
         sts_q <= STS_OK;
      end else if (state_q == S_EXEC) begin
         bal_q <= bal_d;
         sts_q <= sts_d;
      end
   end

   assign balance = bal_q;

`ifdef ATM_DAILY_LIMIT_EN
   logic [31:0] acc_q;

   assign lim_hit = (acc_q + 32'(amt_q)) > 32'(DAILY_LIMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           acc_q <= '0;
      else if (day_clr)                   acc_q <= '0;
      else if (state_q == S_EXEC && wd_ok) acc_q <= acc_q + 32'(amt_q);
   end
`else
   logic unused_lim;

   assign lim_hit    = 1'b0;
   assign unused_lim = day_clr | wd_ok | (DAILY_LIMIT < 0);
`endif

endmodule

// File: tb/tb_balance_access_arbiter.sv
// Directed bench for balance_access_arbiter; limit checks follow ATM_DAILY_LIMIT_EN.
module tb_balance_access_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [23:0] amt;
   logic        day_clr;
   logic [3:0]  ack;
   logic [2:0]  status;
   logic [7:0]  balance;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [1:0] WD  = 2'b00;
   localparam logic [1:0] DEP = 2'b01;
   localparam logic [1:0] INQ = 2'b10;
   localparam logic [1:0] BAD = 2'b11;

   localparam logic [2:0] OK    = 3'b000;
   localparam logic [2:0] NSF   = 3'b001;
   localparam logic [2:0] OVF   = 3'b010;
   localparam logic [2:0] LIMIT = 3'b011;
   localparam logic [2:0] BADOP = 3'b100;

   balance_access_arbiter dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .op      (op),
      .amt     (amt),
      .day_clr (day_clr),
      .ack     (ack),
      .status  (status),
      .balance (balance),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input string tag, output logic [3:0] a);
      a = '0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ack != 4'b0000) begin
            a = ack;
            return;
         end
      end
      n_chk++;
      n_fail++;
      $error("FAIL %s: observed no ack expected ack within 8 cycles", tag);
   endtask

   // Drive one request, scramble the inputs right after the grant edge,
   // then check the ack lands exactly on the third edge.
   task automatic txn(input string tag, input int t, input logic [1:0] o,
                      input logic [5:0] a, input logic [2:0] es,
                      input logic [7:0] eb);
      @(negedge clk);
      req = 4'b0001 << t;
      op  = (8'hFF & ~(8'h03 << (2*t))) | ({6'b0, o} << (2*t));
      amt = (24'hFFFFFF & ~(24'h3F << (6*t))) | ({18'b0, a} << (6*t));
      @(posedge clk); #1;
      req = '0;
      op  = '1;
      amt = '1;
      chk({tag, ".busy"}, 32'(busy), 1);
      @(posedge clk); #1;
      chk({tag, ".early"}, 32'(ack), 0);
      @(posedge clk); #1;
      chk({tag, ".ack"}, 32'(ack), 32'(1) << t);
      chk({tag, ".status"}, 32'(status), 32'(es));
      chk({tag, ".balance"}, 32'(balance), 32'(eb));
      @(posedge clk); #1;
      chk({tag, ".pulse"}, 32'(ack), 0);
      chk({tag, ".idle"}, 32'(busy), 0);
   endtask

   initial begin
      logic [3:0] a;
      logic [3:0] exp_ack [3];
      logic [7:0] exp_bal [3];
      logic [3:0] seen;

      exp_ack = '{4'b0010, 4'b0100, 4'b0010};
      exp_bal = '{8'd35, 8'd40, 8'd45};

      rst     = 1'b0;
      req     = '0;
      op      = '0;
      amt     = '0;
      day_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset.balance", 32'(balance), 50);
      chk("reset.ack", 32'(ack), 0);
      chk("reset.status", 32'(status), 0);
      chk("reset.busy", 32'(busy), 0);
      rst = 1'b1;

      txn("wd20", 0, WD, 6'd20, OK, 8'd30);

      @(negedge clk);
      req = 4'b0110;
      op  = 8'b11_01_01_11;
      amt = {6'd63, 6'd5, 6'd5, 6'd63};
      for (int k = 0; k < 3; k++) begin
         wait_ack("rr.wait", a);
         chk("rr.ack", 32'(a), 32'(exp_ack[k]));
         chk("rr.status", 32'(status), 32'(OK));
         chk("rr.balance", 32'(balance), 32'(exp_bal[k]));
         if (k == 2) req = '0;
         @(negedge clk);
         chk("rr.pulse", 32'(ack), 0);
      end
      chk("rr.idle", 32'(busy), 0);

      txn("dep5", 3, DEP, 6'd5, OK, 8'd50);
      txn("nsf", 0, WD, 6'd51, NSF, 8'd50);
      txn("dep63a", 1, DEP, 6'd63, OK, 8'd113);
      txn("dep63b", 1, DEP, 6'd63, OK, 8'd176);
      txn("dep63c", 1, DEP, 6'd63, OK, 8'd239);
      txn("dep11", 1, DEP, 6'd11, OK, 8'd250);
      txn("ovf", 2, DEP, 6'd10, OVF, 8'd250);
      txn("inq", 3, INQ, 6'd7, OK, 8'd250);
      txn("badop", 0, BAD, 6'd5, BADOP, 8'd250);
      txn("dep0", 1, DEP, 6'd0, OK, 8'd250);
      txn("wd0", 2, WD, 6'd0, OK, 8'd250);

      txn("lim40a", 0, WD, 6'd40, OK, 8'd210);
      txn("lim40b", 1, WD, 6'd40, OK, 8'd170);
`ifdef ATM_DAILY_LIMIT_EN
      txn("lim30", 2, WD, 6'd30, LIMIT, 8'd170);
`else
      txn("lim30", 2, WD, 6'd30, OK, 8'd140);
`endif
      @(negedge clk);
      day_clr = 1'b1;
      @(negedge clk);
      day_clr = 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
      txn("clr30", 3, WD, 6'd30, OK, 8'd140);
`else
      txn("clr30", 3, WD, 6'd30, OK, 8'd110);
`endif

      @(negedge clk);
      req = 4'b0100;
      op  = 8'b11_00_11_11;
      amt = {6'd63, 6'd10, 6'd63, 6'd63};
      @(posedge clk); #1;
      req = '0;
      @(posedge clk); #1;
      chk("abort.exec_busy", 32'(busy), 1);
      rst = 1'b0;
      #1;
      chk("abort.busy", 32'(busy), 0);
      chk("abort.balance", 32'(balance), 50);
      @(negedge clk);
      chk("abort.next_ack", 32'(ack), 0);
      chk("abort.next_busy", 32'(busy), 0);
      chk("abort.next_status", 32'(status), 0);
      chk("abort.next_balance", 32'(balance), 50);
      rst  = 1'b1;
      seen = '0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | ack;
      end
      chk("abort.no_ack", 32'(seen), 0);

      @(negedge clk);
      req = 4'b1010;
      op  = 8'b10_10_10_10;
      amt = '0;
      wait_ack("rrrst.wait", a);
      chk("rrrst.ack", 32'(a), 32'(4'b0010));
      chk("rrrst.balance", 32'(balance), 50);
      req = '0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/balance_access_arbiter.md
BALANCE_ACCESS_ARBITER -- requirements
Module: balance_access_arbiter

Interface
REQ-001 SHALL have parameter NUM_TERM, default 4: number of requesting terminals.
REQ-002 SHALL have parameter BAL_W, default 8: balance width.
REQ-003 SHALL have parameter AMT_W, default 6: transaction amount width.
REQ-004 SHALL have parameter INIT_BAL, default 50: balance value after reset.
REQ-005 SHALL have parameter DAILY_LIMIT, default 100: cumulative withdraw cap; used only under REQ-030.
REQ-006 SHALL have port clk  in  1  clock; all state updates on posedge clk.
REQ-007 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have port req  in  NUM_TERM  per-terminal transaction request, level.
REQ-009 SHALL have port op  in  2*NUM_TERM  per-terminal opcode, terminal i at bits [2i+1:2i].
REQ-010 SHALL have port amt  in  AMT_W*NUM_TERM  per-terminal amount, terminal i at slice i.
REQ-011 SHALL have port day_clr  in  1  one-cycle pulse clearing the withdraw accumulator.
REQ-012 SHALL have port ack  out  NUM_TERM  one-hot, one-cycle completion pulse.
REQ-013 SHALL have port status  out  3  result code, valid only while ack is nonzero.
REQ-014 SHALL have port balance  out  BAL_W  current shared balance, registered.
REQ-015 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL use opcodes: 00 withdraw, 01 deposit, 10 inquiry, 11 invalid.
REQ-017 SHALL use status codes: 000 OK, 001 NSF, 010 OVF, 011 LIMIT, 100 BADOP.
REQ-018 SHALL run FSM IDLE -> GRANT -> EXEC -> RESP -> IDLE, one cycle per state except IDLE.
REQ-019 SHALL, in IDLE with any req bit high, select one winner round-robin and latch its index, op and amt into GRANT.
REQ-020 SHALL start round-robin priority at terminal 0 after reset and, after each grant, give lowest priority to the last winner.
REQ-021 SHALL, in EXEC, compute the result from latched values only; later changes on req, op or amt SHALL NOT affect the transaction.
REQ-022 SHALL apply a withdraw with amt > balance as status NSF, leaving balance unchanged.
REQ-023 SHALL apply a deposit whose sum exceeds 2^BAL_W-1 as status OVF, leaving balance unchanged; no wrap-around.
REQ-024 SHALL treat amt==0 on withdraw or deposit as OK with balance unchanged.
REQ-025 SHALL treat inquiry as OK with no change, and opcode 11 as BADOP with no change.
REQ-026 SHALL update balance at the EXEC->RESP edge, pulse ack[winner] and drive status for exactly the RESP cycle; ack SHALL rise 3 cycles after the req sample edge.
REQ-027 SHALL complete and ack a granted transaction even if its req drops before RESP; a req still high after ack SHALL re-compete normally.

Reset
REQ-028 SHALL, on rst low at any time including mid-transaction: enter IDLE; set balance=INIT_BAL, ack=0, status=000, busy=0, RR pointer=0 and accumulator=0; issue no ack for the aborted transaction.

Configuration
REQ-029 SHALL compile the daily-limit feature only when macro ATM_DAILY_LIMIT_EN is defined.
REQ-030 SHALL, with ATM_DAILY_LIMIT_EN defined: keep an accumulator of successful withdraws; reject a withdraw with accum+amt > DAILY_LIMIT as LIMIT, checked before NSF; clear the accumulator on day_clr, which takes priority over a same-cycle add.
REQ-031 SHALL, without ATM_DAILY_LIMIT_EN: keep the day_clr port but ignore it; never produce LIMIT.

Structure
REQ-032 SHALL place opcode and status constants in shared package atm_pkg.
REQ-033 SHALL implement winner selection in sub-module atm_rr_arbiter, parameterised by NUM_TERM.

Verification
REQ-034 SHALL cover: reset, then req[0] withdraw 20 -> ack[0] 3 cycles later, status OK, balance 30.
REQ-035 SHALL cover: req[1] and req[2] asserted together, then held -> grants in order 1, 2, 1, with one ack per transaction.
REQ-036 SHALL cover: balance 50, withdraw 51 -> NSF, balance 50; balance 250, deposit 10 -> OVF, balance 250.
REQ-037 SHALL cover: with the macro, withdraws 40, 40, 30 -> OK, OK, LIMIT; then day_clr and withdraw 30 -> OK.
REQ-038 SHALL cover: rst asserted during EXEC -> no ack, balance 50, busy 0 on the next cycle.
